rggen_bus_arbiter: RTL



---
 rtl/rggen_bus_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/rggen_bus_arbiter.sv
// Round-robin arbiter sharing one downstream rggen bus between REQUESTERS
// upstream masters. One whole transaction is granted at a time; the grant is
// registered, and request/response fields are steered through the grant.
module rggen_bus_arbiter #(
   parameter int unsigned REQUESTERS    = 2,
   parameter int unsigned ADDRESS_WIDTH = 16,
   parameter int unsigned BUS_WIDTH     = 32
) (
   input  logic                                  i_clk,
   input  logic                                  i_rst_n,
   input  logic [REQUESTERS-1:0]                 i_valid,
   input  logic [REQUESTERS-1:0]                 i_write,
   input  logic [REQUESTERS*ADDRESS_WIDTH-1:0]   i_address,
   input  logic [REQUESTERS*BUS_WIDTH-1:0]       i_write_data,
   input  logic [REQUESTERS*(BUS_WIDTH/8)-1:0]   i_strobe,
   output logic [REQUESTERS-1:0]                 o_ready,
   output logic [REQUESTERS*2-1:0]               o_status,
   output logic [REQUESTERS*BUS_WIDTH-1:0]       o_read_data,
   output logic                                  o_valid,
   output logic                                  o_write,
   output logic [ADDRESS_WIDTH-1:0]              o_address,
   output logic [BUS_WIDTH-1:0]                  o_write_data,
   output logic [BUS_WIDTH/8-1:0]                o_strobe,
   input  logic                                  i_ready,
   input  logic [1:0]                            i_status,
   input  logic [BUS_WIDTH-1:0]                  i_read_data,
   output logic [REQUESTERS-1:0]                 o_grant
);

   localparam int unsigned STRB_W = BUS_WIDTH / 8;
   localparam int unsigned PTR_W  = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t                  r_state;
   logic [REQUESTERS-1:0]   r_grant;
   logic [PTR_W-1:0]        r_ptr;

   logic [REQUESTERS-1:0]   w_sel;
   logic [PTR_W-1:0]        w_next_ptr;
   logic                    w_busy;

   assign w_busy  = (r_state == BUSY);
   assign o_grant = r_grant;

   // Round-robin pick: requester with the smallest circular distance from r_ptr
   always_comb begin
      int unsigned l_ptr;
      int unsigned l_dist;
      int unsigned l_best;
      int unsigned l_idx;
      w_sel  = '0;
      l_ptr  = 32'(r_ptr);
      l_dist = 0;
      l_best = REQUESTERS;
      l_idx  = 0;
      for (int unsigned k = 0; k < REQUESTERS; k++) begin
         l_dist = (k >= l_ptr) ? (k - l_ptr) : (k + REQUESTERS - l_ptr);
         if (i_valid[k] && (l_dist < l_best)) begin
            l_best = l_dist;
            l_idx  = k;
         end
      end
      for (int unsigned k = 0; k < REQUESTERS; k++) begin
         w_sel[k] = (l_best < REQUESTERS) && (k == l_idx);
      end
   end

   // Priority pointer for the next round: one past the current owner, wrapping
   always_comb begin
      w_next_ptr = '0;
      for (int unsigned k = 0; k < REQUESTERS; k++) begin
         if (r_grant[k]) begin
            w_next_ptr = (k + 1 == REQUESTERS) ? '0 : PTR_W'(k + 1);
         end
      end
   end

   // Downstream request: OR-mux of the granted master's slice (grant is one-hot or 0)
   always_comb begin
      o_valid      = 1'b0;
      o_write      = 1'b0;
      o_address    = '0;
      o_write_data = '0;
      o_strobe     = '0;
      for (int unsigned k = 0; k < REQUESTERS; k++) begin
         if (w_busy && r_grant[k]) begin
            o_valid      = o_valid | i_valid[k];
            o_write      = o_write | i_write[k];
            o_address    = o_address    | i_address[k*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            o_write_data = o_write_data | i_write_data[k*BUS_WIDTH +: BUS_WIDTH];
            o_strobe     = o_strobe     | i_strobe[k*STRB_W +: STRB_W];
         end
      end
   end

   // Upstream response: only the granted master sees ready, status and read data
   always_comb begin
      o_ready     = '0;
      o_status    = '0;
      o_read_data = '0;
      for (int unsigned k = 0; k < REQUESTERS; k++) begin
         if (w_busy && r_grant[k] && i_ready) begin
            o_ready[k]                           = 1'b1;
            o_status[k*2 +: 2]                   = i_status;
            o_read_data[k*BUS_WIDTH +: BUS_WIDTH] = i_read_data;
         end
      end
   end

   // Arbitration FSM: grant in IDLE, release and advance the pointer on completion
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
         r_grant <= '0;
         r_ptr   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (|i_valid) begin
                  r_grant <= w_sel;
                  r_state <= BUSY;
               end
            end
            BUSY: begin
               if (i_ready) begin
                  r_grant <= '0;
                  r_ptr   <= w_next_ptr;
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
               r_grant <= '0;
            end
         endcase
      end
   end

endmodule
